load_v_arbiter: RTL and testbench
=================================

// Module: load_v_arbiter
// PURPOSE
//  Shares one load_v vector-tile loader among NUM_REQ requesters (input vector, bias, residual, ...).
//  Round-robin grant; each grant owns the loader for one full transfer.
//  Latches the winner's addr/len, issues the lv_valid_in pulse and routes per-tile and done strobes
//  back to the owner. Tile data (data_out) bypasses this block; the owner samples it on tile_vld_o.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  ADDR_WIDTH  24  DRAM byte address width
//  LEN_WIDTH   10  transfer length width, in elements
//  TILE_CNT_W  6   tile index counter width
// PORTS
//  clk         in   1                    clock
//  rst_n       in   1                    asynchronous active-low reset
//  req_i       in   NUM_REQ              level request per requester
//  addr_i      in   NUM_REQ*ADDR_WIDTH   packed start address; slice i for requester i
//  len_i       in   NUM_REQ*LEN_WIDTH    packed length in elements; slice i
//  gnt_o       out  NUM_REQ              one-hot owner; high from ISSUE through COMPLETE
//  tile_vld_o  out  NUM_REQ              owner's strobe; one cycle per tile delivered
//  tile_idx_o  out  TILE_CNT_W           index of the tile currently strobed (0-based)
//  done_o      out  NUM_REQ              one-cycle end-of-transfer pulse to the owner
//  len_err_o   out  NUM_REQ              one-cycle zero-length reject (macro only; else 0)
//  busy_o      out  1                    state != IDLE
//  proto_err_o out  1                    sticky: lv_tile_out/lv_valid_out seen outside BUSY
//  lv_valid_in out  1                    start pulse to load_v
//  lv_dram_addr out ADDR_WIDTH           latched address to load_v
//  lv_length   out  LEN_WIDTH            latched length to load_v
//  lv_tile_out in   1                    load_v tile-ready strobe
//  lv_valid_out in  1                    load_v transfer-complete strobe
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; rr pointer=NUM_REQ-1, so requester 0 wins first.
//  Reset is asynchronous; deassertion is synchronised by the integrator.
//  load_v reset must be driven from the same source (load_v rst = ~rst_n). Mid-transfer reset: abort, no done.
//  FSM:
//   IDLE     - any req_i: pick first set bit searching ptr+1..ptr (mod NUM_REQ);
//              latch addr/len slice, set gnt, ptr<=winner, ->ISSUE
//   ISSUE    - lv_valid_in=1 for exactly this cycle, tile_cnt<=0, ->BUSY
//   BUSY     - lv_tile_out: tile_vld_o[owner]=1 same cycle (combinational from input),
//              tile_idx_o=tile_cnt, tile_cnt++ (saturates at all-ones)
//              lv_valid_out: ->COMPLETE. Same-cycle tile_out+valid_out still produces the final tile strobe.
//   COMPLETE - done_o[owner]=1, gnt cleared at exit, ->IDLE
//  Minimum gap: lv_valid_in re-asserts >=2 cycles after lv_valid_out, covering load_v DONE->IDLE.
//  Requester protocol: hold addr/len stable while req high until done; drop req the cycle after done.
//   A req still high in IDLE after done is a new request.
//  req deassert while granted: ignored; transfer completes, done still pulsed.
//  Unrequested slices are don't-care. Simultaneous requests: round-robin only, no priority.
//  proto_err_o sets on lv_tile_out or lv_valid_out in IDLE/ISSUE/COMPLETE; clears only on reset.
//  tile_vld_o, done_o, len_err_o are all zero-or-one-hot.
// CONFIGURATION
//  LOAD_V_ARB_LEN_CHECK_EN
//   defined: IDLE winner with len==0 is not issued. Next cycle is COMPLETE with done_o[i]=1 and
//            len_err_o[i]=1, no tiles. ptr still advances.
//   undefined: len==0 forwarded as-is; load_v returns one zero-filled tile then valid_out.
//              len_err_o tied 0.
// TESTING
//  1 req0 addr=0x000100 len=32 -> lv_valid_in 1 cycle, lv_dram_addr=0x000100, lv_length=32;
//    one tile_vld_o[0] with idx 0; done_o[0]; gnt_o=0 after.
//  2 req0 len=70 -> three tile_vld_o[0] strobes, idx 0,1,2; last coincides with lv_valid_out;
//    done_o[0] next cycle.
//  3 req0..3 all high from reset -> grant order 0,1,2,3,0; each lv_valid_in >=2 cycles after
//    previous lv_valid_out.
//  4 req2 len=0: macro on -> done_o[2]+len_err_o[2], no lv_valid_in;
//    macro off -> 1 tile strobe then done_o[2].
//  5 rst_n low while BUSY mid-tile -> all outputs 0 immediately; req1 after release granted first
//    (ptr reset); no stale done.
//  6 lv_tile_out pulsed in IDLE -> proto_err_o=1 and stays 1; no tile_vld_o; arbitration unaffected.

Source files
------------

// File: rtl/load_v_arbiter.sv
// ---------------------------------------------------------------------------
// load_v_arbiter
//
// Shares a single load_v vector-tile loader among NUM_REQ requesters
// (input vector, bias, residual, ...). A round-robin arbiter picks one
// requester. That requester then owns the loader for one complete transfer.
//
// The arbiter latches the winner's address and length, and issues a
// one-cycle lv_valid_in start pulse. It then routes the loader's per-tile
// and completion strobes back to the owner. Tile data itself does not pass
// through here: the owner samples load_v's data_out when its tile_vld_o bit
// is high.
//
// Optional feature (compile-time macro):
//   LOAD_V_ARB_LEN_CHECK_EN
//     - defined:   a zero-length request is never issued to load_v. The
//                  owner gets done_o together with len_err_o.
//     - undefined: zero-length requests are forwarded unchanged, and
//                  len_err_o is tied to 0.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   req_i           level request, one bit per requester
//   addr_i, len_i   packed per-requester start address / element count
//   gnt_o           one-hot owner, from ISSUE through COMPLETE
//   tile_vld_o      owner's per-tile strobe (combinational from lv_tile_out)
//   tile_idx_o      0-based index of the tile being strobed
//   done_o          one-cycle end-of-transfer pulse to the owner
//   len_err_o       one-cycle zero-length reject pulse (macro build only)
//   busy_o          arbiter is not idle
//   proto_err_o     sticky: loader strobe seen while no transfer in flight
//   lv_valid_in     start pulse to load_v
//   lv_dram_addr    latched address to load_v
//   lv_length       latched length to load_v
//   lv_tile_out     load_v tile-ready strobe
//   lv_valid_out    load_v transfer-complete strobe
// ---------------------------------------------------------------------------
module load_v_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int LEN_WIDTH  = 10,
    parameter int TILE_CNT_W = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    len_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              tile_vld_o,
    output logic [TILE_CNT_W-1:0]           tile_idx_o,
    output logic [NUM_REQ-1:0]              done_o,
    output logic [NUM_REQ-1:0]              len_err_o,
    output logic                            busy_o,
    output logic                            proto_err_o,
    output logic                            lv_valid_in,
    output logic [ADDR_WIDTH-1:0]           lv_dram_addr,
    output logic [LEN_WIDTH-1:0]            lv_length,
    input  logic                            lv_tile_out,
    input  logic                            lv_valid_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_BUSY     = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    // ptr holds the last winner, which is also the current owner while the
    // arbiter is not idle.
    logic [PTR_W-1:0]       ptr;
    logic [NUM_REQ-1:0]     gnt_q;
    logic [TILE_CNT_W-1:0]  tile_cnt;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic                   proto_err_q;

    logic                   win_found;
    logic [PTR_W-1:0]       win_idx;
    logic                   zero_len;

    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0]   len_arr  [NUM_REQ];

    // Unpack the per-requester slices so the winner can be selected by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign len_arr[g]  = len_i[g*LEN_WIDTH +: LEN_WIDTH];
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // The tile counter sticks at all-ones so an oversized transfer cannot
    // wrap back to index 0.
    function automatic logic [TILE_CNT_W-1:0] sat_inc(input logic [TILE_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Round-robin search: start just after the last winner and wrap round,
    // so the last winner has the lowest priority.
    always_comb begin
        int unsigned       cand;
        logic [PTR_W-1:0]  cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (!win_found && req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

`ifdef LOAD_V_ARB_LEN_CHECK_EN
    logic len_err_q;
    assign zero_len = (len_arr[win_idx] == '0);
`else
    assign zero_len = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lv_valid_in = 1'b0;
        tile_vld_o  = '0;
        done_o      = '0;
        len_err_o   = '0;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt = zero_len ? S_COMPLETE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                lv_valid_in = 1'b1;
                state_nxt   = S_BUSY;
            end
            S_BUSY: begin
                // A tile strobe arriving together with valid_out is still
                // forwarded; it is the final tile of the transfer.
                if (lv_tile_out) begin
                    tile_vld_o = gnt_q;
                end
                if (lv_valid_out) begin
                    state_nxt = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                done_o    = gnt_q;
`ifdef LOAD_V_ARB_LEN_CHECK_EN
                len_err_o = len_err_q ? gnt_q : '0;
`endif
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= PTR_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            tile_cnt    <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            proto_err_q <= 1'b0;
`ifdef LOAD_V_ARB_LEN_CHECK_EN
            len_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        ptr    <= win_idx;
                        gnt_q  <= onehot(win_idx);
                        addr_q <= addr_arr[win_idx];
                        len_q  <= len_arr[win_idx];
`ifdef LOAD_V_ARB_LEN_CHECK_EN
                        len_err_q <= zero_len;
`endif
                    end
                end
                S_ISSUE: begin
                    tile_cnt <= '0;
                end
                S_BUSY: begin
                    if (lv_tile_out) begin
                        tile_cnt <= sat_inc(tile_cnt);
                    end
                end
                S_COMPLETE: begin
                    gnt_q <= '0;
`ifdef LOAD_V_ARB_LEN_CHECK_EN
                    len_err_q <= 1'b0;
`endif
                end
                default: ;
            endcase
            // load_v must be silent unless a transfer is in flight.
            if ((lv_tile_out || lv_valid_out) && (state != S_BUSY)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign gnt_o        = gnt_q;
    assign tile_idx_o   = tile_cnt;
    assign busy_o       = (state != S_IDLE);
    assign proto_err_o  = proto_err_q;
    assign lv_dram_addr = addr_q;
    assign lv_length    = len_q;

endmodule

// File: tb/tb_load_v_arbiter.sv
module tb_load_v_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 24;
    localparam int LW      = 10;
    localparam int TW      = 6;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_i;
    logic [NUM_REQ*AW-1:0]  addr_i;
    logic [NUM_REQ*LW-1:0]  len_i;
    logic [NUM_REQ-1:0]     gnt_o;
    logic [NUM_REQ-1:0]     tile_vld_o;
    logic [TW-1:0]          tile_idx_o;
    logic [NUM_REQ-1:0]     done_o;
    logic [NUM_REQ-1:0]     len_err_o;
    logic                   busy_o;
    logic                   proto_err_o;
    logic                   lv_valid_in;
    logic [AW-1:0]          lv_dram_addr;
    logic [LW-1:0]          lv_length;
    logic                   lv_tile_out;
    logic                   lv_valid_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_vo = -100;

    load_v_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TILE_CNT_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .len_i(len_i),
        .gnt_o(gnt_o), .tile_vld_o(tile_vld_o), .tile_idx_o(tile_idx_o),
        .done_o(done_o), .len_err_o(len_err_o), .busy_o(busy_o),
        .proto_err_o(proto_err_o), .lv_valid_in(lv_valid_in),
        .lv_dram_addr(lv_dram_addr), .lv_length(lv_length),
        .lv_tile_out(lv_tile_out), .lv_valid_out(lv_valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           req;
        logic [23:0]  addr;
        logic [9:0]   len;
        int           ntiles;
        logic [3:0]   exp_gnt;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [23:0] a, input logic [9:0] l);
        addr_i[i*AW +: AW] = a;
        len_i[i*LW +: LW]  = l;
        req_i[i]           = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        req_i        = '0;
        lv_tile_out  = 1'b0;
        lv_valid_out = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Plays the load_v side of one transfer for the expected owner.
    // Returns at the negedge of the COMPLETE cycle.
    task automatic serve(input logic [3:0] exp_gnt, input logic [23:0] a,
                         input logic [9:0] l, input int nt);
        bit found;
        int exp_idx;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lv_valid_in) begin
                found = 1'b1;
                break;
            end
        end
        chk("issue_seen", 64'(found), 64'd1);
        if (!found) return;
        chk("gnt", 64'(gnt_o), 64'(exp_gnt));
        chk("lv_addr", 64'(lv_dram_addr), 64'(a));
        chk("lv_len", 64'(lv_length), 64'(l));
        chk("gap_ok", 64'(cyc - last_vo >= 2), 64'd1);
        for (int t = 0; t < nt; t++) begin
            @(posedge clk);
            #1;
            lv_tile_out  = 1'b1;
            lv_valid_out = (t == nt - 1);
            if (t == nt - 1) last_vo = cyc;
            @(negedge clk);
            exp_idx = (t < 63) ? t : 63;
            chk("tile_vld", 64'(tile_vld_o), 64'(exp_gnt));
            chk("tile_idx", 64'(tile_idx_o), 64'(exp_idx));
            if (t != nt - 1) begin
                @(posedge clk);
                #1;
                lv_tile_out = 1'b0;
                @(negedge clk);
                chk("tile_gap", 64'(tile_vld_o), 64'd0);
            end
        end
        @(posedge clk);
        #1;
        lv_tile_out  = 1'b0;
        lv_valid_out = 1'b0;
        @(negedge clk);
        chk("done", 64'(done_o), 64'(exp_gnt));
        chk("len_err_clr", 64'(len_err_o), 64'd0);
        chk("gnt_hold", 64'(gnt_o), 64'(exp_gnt));
    endtask

    task automatic drop_and_check_idle();
        @(posedge clk);
        #1;
        req_i = '0;
        @(negedge clk);
        chk("gnt_after", 64'(gnt_o), 64'd0);
        chk("busy_after", 64'(busy_o), 64'd0);
        chk("done_after", 64'(done_o), 64'd0);
    endtask

    vec_t vecs[5];

    initial begin
        rst_n        = 1'b0;
        req_i        = '0;
        addr_i       = '0;
        len_i        = '0;
        lv_tile_out  = 1'b0;
        lv_valid_out = 1'b0;

        vecs[0] = '{req: 0, addr: 24'h000100, len: 10'd32,   ntiles: 1,  exp_gnt: 4'b0001};
        vecs[1] = '{req: 0, addr: 24'h002000, len: 10'd70,   ntiles: 3,  exp_gnt: 4'b0001};
        vecs[2] = '{req: 3, addr: 24'hABCDEF, len: 10'd64,   ntiles: 2,  exp_gnt: 4'b1000};
        vecs[3] = '{req: 1, addr: 24'h123456, len: 10'd1,    ntiles: 1,  exp_gnt: 4'b0010};
        vecs[4] = '{req: 2, addr: 24'hFFFFFF, len: 10'd1023, ntiles: 66, exp_gnt: 4'b0100};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_vin", 64'(lv_valid_in), 64'd0);
        chk("rst_addr", 64'(lv_dram_addr), 64'd0);
        chk("rst_len", 64'(lv_length), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_proto", 64'(proto_err_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-requester transfers.
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            set_req(vecs[i].req, vecs[i].addr, vecs[i].len);
            serve(vecs[i].exp_gnt, vecs[i].addr, vecs[i].len, vecs[i].ntiles);
            drop_and_check_idle();
        end
        chk("no_proto_in_busy", 64'(proto_err_o), 64'd0);

        // All four requesting from reset: 0,1,2,3,0.
        do_reset();
        set_req(0, 24'h000010, 10'd32);
        set_req(1, 24'h000020, 10'd32);
        set_req(2, 24'h000030, 10'd32);
        set_req(3, 24'h000040, 10'd32);
        serve(4'b0001, 24'h000010, 10'd32, 1);
        serve(4'b0010, 24'h000020, 10'd32, 1);
        serve(4'b0100, 24'h000030, 10'd32, 1);
        serve(4'b1000, 24'h000040, 10'd32, 1);
        serve(4'b0001, 24'h000010, 10'd32, 1);
        drop_and_check_idle();

        // Zero-length request from requester 2.
        @(posedge clk);
        #1;
        set_req(2, 24'h000500, 10'd0);
`ifdef LOAD_V_ARB_LEN_CHECK_EN
        begin
            bit seen_done;
            bit seen_vin;
            seen_done = 1'b0;
            seen_vin  = 1'b0;
            for (int k = 0; k < 10 && !seen_done; k++) begin
                @(negedge clk);
                if (lv_valid_in) seen_vin = 1'b1;
                if (done_o != 0) begin
                    seen_done = 1'b1;
                    chk("len0_done", 64'(done_o), 64'h4);
                    chk("len0_err", 64'(len_err_o), 64'h4);
                    chk("len0_gnt", 64'(gnt_o), 64'h4);
                end
            end
            chk("len0_done_seen", 64'(seen_done), 64'd1);
            chk("len0_no_issue", 64'(seen_vin), 64'd0);
        end
`else
        serve(4'b0100, 24'h000500, 10'd0, 1);
`endif
        drop_and_check_idle();

        // Reset while BUSY mid-tile, owner 2; afterwards 1 must beat 3.
        @(posedge clk);
        #1;
        set_req(2, 24'h000600, 10'd100);
        begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (lv_valid_in) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("abort_issue_seen", 64'(found), 64'd1);
        end
        @(posedge clk);
        #1;
        lv_tile_out = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", 64'(gnt_o), 64'd0);
        chk("abort_tile", 64'(tile_vld_o), 64'd0);
        chk("abort_idx", 64'(tile_idx_o), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_addr", 64'(lv_dram_addr), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        lv_tile_out = 1'b0;
        req_i       = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req(1, 24'h000700, 10'd32);
        set_req(3, 24'h000800, 10'd32);
        @(negedge clk);
        chk("post_rst_no_done", 64'(done_o), 64'd0);
        serve(4'b0010, 24'h000700, 10'd32, 1);
        drop_and_check_idle();

        // Stray tile strobe in IDLE.
        do_reset();
        @(posedge clk);
        #1;
        lv_tile_out = 1'b1;
        @(negedge clk);
        chk("stray_no_tile", 64'(tile_vld_o), 64'd0);
        @(posedge clk);
        #1;
        lv_tile_out = 1'b0;
        @(negedge clk);
        chk("proto_set", 64'(proto_err_o), 64'd1);
        chk("proto_idle", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;
        set_req(0, 24'h000900, 10'd32);
        serve(4'b0001, 24'h000900, 10'd32, 1);
        drop_and_check_idle();
        chk("proto_sticky", 64'(proto_err_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
